// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants (fetch stage and fetch_queue).
// No logic; compile before any importer.
// Canonical widths match the default 64-bit PC / 32-bit instruction build.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 64;
  localparam int FETCH_INST_W = 32;

  // Sequential-PC increment, shared with the fetch stage's next-PC adder.
  localparam int PC_INC = 4;

  // One fetched instruction as it travels from fetch to decode.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for fetch_queue: DEPTH x WIDTH register array, no reset.
// Latency: write lands at the clock edge; read is asynchronous (same cycle).
// Backpressure: none; the owner decides when the write enable is asserted.
module fetch_queue_ram #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 96,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Single write port; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction FIFO with flush; optional FETCH_QUEUE_BYPASS_EN.
// Latency: 1 cycle enqueue-to-dequeue (0 on the empty path with bypass).
// Backpressure: enq_ready = !full (registered); decode stalls absorbed until full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_W,
  parameter int INST_WIDTH = FETCH_INST_W,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [ADDR_WIDTH-1:0]    enq_pc,
  input  logic [INST_WIDTH-1:0]    enq_inst,
  output logic                     enq_ready,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [ADDR_WIDTH-1:0]    deq_pc,
  output logic [ADDR_WIDTH-1:0]    deq_pc4,
  output logic [INST_WIDTH-1:0]    deq_inst,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Same shape as fetch_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             enq_fire, deq_fire, byp_take;
  entry_t           enq_entry, ram_rdata, head;

  assign enq_entry = '{pc: enq_pc, inst: enq_inst};

  // Flags come only from the pointer registers; the top bit is the wrap bit.
  assign count     = wptr_q - rptr_q;
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                     (wptr_q[IDX_W] != rptr_q[IDX_W]);
  assign enq_ready = !full;

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (wptr_q[IDX_W-1:0]),
    .wdata (enq_entry),
    .raddr (rptr_q[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  // Head selection, handshake qualification and next-pointer computation.
  always_comb begin
    head      = ram_rdata;
    deq_valid = !empty && !flush;
    byp_take  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the incoming entry directly; if decode takes it
    // now it never touches storage.
    if (empty) begin
      head      = enq_entry;
      deq_valid = enq_valid && !flush;
    end
    byp_take = empty && enq_valid && !flush && deq_ready;
`endif
    deq_fire = deq_valid && deq_ready && !empty;
    enq_fire = enq_valid && !full && !flush && !byp_take;

    deq_pc   = deq_valid ? head.pc : '0;
    deq_pc4  = deq_valid ? head.pc + ADDR_WIDTH'(PC_INC) : '0;
    deq_inst = deq_valid ? head.inst : '0;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (enq_fire) wptr_d = wptr_q + PTR_W'(1);
      if (deq_fire) rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // Pointer registers; reset empties the queue without needing an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, corner sequences,
// randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam int CW = 3;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, flush, enq_valid, deq_ready;
  logic [AW-1:0] enq_pc, deq_pc, deq_pc4;
  logic [IW-1:0] enq_inst, deq_inst;
  logic          enq_ready, deq_valid, empty, full;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
    .enq_ready(enq_ready), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_pc4(deq_pc4), .deq_inst(deq_inst),
    .empty(empty), .full(full), .count(count)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  typedef struct {
    logic          f, ev, dr;
    logic [AW-1:0] pc;
    logic          e_dv;
    logic [AW-1:0] e_pc, e_pc4;
    logic [CW-1:0] e_cnt;
    logic          e_full, e_empty;
  } vec_t;

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
    return ~pc[IW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply inputs mid-cycle (after the falling edge); outputs settle 1 ns later.
  task automatic drive(input logic f, input logic ev, input logic [AW-1:0] pc, input logic dr);
    @(negedge clk);
    flush     = f;
    enq_valid = ev;
    enq_pc    = pc;
    enq_inst  = inst_of(pc);
    deq_ready = dr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_inst = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vec[10];
  ent_t mq[$];

  initial begin
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_inst = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_deq_pc", deq_pc, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- fill / overflow / drain table ----
    vec[0] = '{1'b0, 1'b1, 1'b0, 64'h1000, BYP, BYP ? 64'h1000 : 64'h0, BYP ? 64'h1004 : 64'h0, 3'd0, 1'b0, 1'b1};
    vec[1] = '{1'b0, 1'b1, 1'b0, 64'h1004, 1'b1, 64'h1000, 64'h1004, 3'd1, 1'b0, 1'b0};
    vec[2] = '{1'b0, 1'b1, 1'b0, 64'h1008, 1'b1, 64'h1000, 64'h1004, 3'd2, 1'b0, 1'b0};
    vec[3] = '{1'b0, 1'b1, 1'b0, 64'h100C, 1'b1, 64'h1000, 64'h1004, 3'd3, 1'b0, 1'b0};
    vec[4] = '{1'b0, 1'b1, 1'b0, 64'h1010, 1'b1, 64'h1000, 64'h1004, 3'd4, 1'b1, 1'b0};
    vec[5] = '{1'b0, 1'b0, 1'b1, 64'h0,    1'b1, 64'h1000, 64'h1004, 3'd4, 1'b1, 1'b0};
    vec[6] = '{1'b0, 1'b0, 1'b1, 64'h0,    1'b1, 64'h1004, 64'h1008, 3'd3, 1'b0, 1'b0};
    vec[7] = '{1'b0, 1'b0, 1'b1, 64'h0,    1'b1, 64'h1008, 64'h100C, 3'd2, 1'b0, 1'b0};
    vec[8] = '{1'b0, 1'b0, 1'b1, 64'h0,    1'b1, 64'h100C, 64'h1010, 3'd1, 1'b0, 1'b0};
    vec[9] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    64'h0,    3'd0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(vec[i].f, vec[i].ev, vec[i].pc, vec[i].dr);
      chk($sformatf("vec%0d_deq_valid", i), deq_valid, vec[i].e_dv);
      chk($sformatf("vec%0d_deq_pc", i), deq_pc, vec[i].e_pc);
      chk($sformatf("vec%0d_deq_pc4", i), deq_pc4, vec[i].e_pc4);
      chk($sformatf("vec%0d_deq_inst", i), deq_inst, vec[i].e_dv ? 64'(inst_of(vec[i].e_pc)) : 64'h0);
      chk($sformatf("vec%0d_count", i), count, vec[i].e_cnt);
      chk($sformatf("vec%0d_full", i), full, vec[i].e_full);
      chk($sformatf("vec%0d_empty", i), empty, vec[i].e_empty);
      chk($sformatf("vec%0d_enq_ready", i), enq_ready, !vec[i].e_full);
    end

    // ---- steady stream across pointer wrap: count stays 1 ----
    drive(1'b0, 1'b1, 64'h5000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 64'h5004 + 64'(4 * i), 1'b1);
      chk($sformatf("stream%0d_count", i), count, 1);
      chk($sformatf("stream%0d_deq_pc", i), deq_pc, 64'h5000 + 64'(4 * i));
    end
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    chk("stream_last_pc", deq_pc, 64'h5050);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    chk("stream_empty", empty, 1);

    // ---- PC wrap: pc4 of top address is 0 ----
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    chk("wrap_deq_pc", deq_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_deq_pc4", deq_pc4, 0);
    chk("wrap_deq_valid", deq_valid, 1);

    // ---- flush with 3 entries and same-cycle enqueue ----
    drive(1'b0, 1'b1, 64'h1100, 1'b0);
    drive(1'b0, 1'b1, 64'h1104, 1'b0);
    drive(1'b0, 1'b1, 64'h1108, 1'b0);
    drive(1'b1, 1'b1, 64'h2000, 1'b1);
    chk("flush_deq_valid", deq_valid, 0);
    chk("flush_deq_pc", deq_pc, 0);
    chk("flush_count_before", count, 3);
    drive(1'b0, 1'b1, 64'h3000, 1'b0);
    chk("post_flush_count", count, 0);
    chk("post_flush_empty", empty, 1);
    chk("post_flush_enq_ready", enq_ready, 1);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    chk("post_flush_head", deq_pc, 64'h3000);
    chk("post_flush_dv", deq_valid, 1);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    chk("post_flush_drained", empty, 1);

`ifdef FETCH_QUEUE_BYPASS_EN
    // ---- bypass on empty path ----
    drive(1'b0, 1'b1, 64'h4000, 1'b1);
    chk("byp_deq_valid", deq_valid, 1);
    chk("byp_deq_pc", deq_pc, 64'h4000);
    chk("byp_deq_inst", deq_inst, inst_of(64'h4000));
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    chk("byp_count", count, 0);
    chk("byp_empty", empty, 1);
    drive(1'b1, 1'b1, 64'h4100, 1'b1);
    chk("byp_flush_dv", deq_valid, 0);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    chk("byp_flush_count", count, 0);
`endif

    // ---- asynchronous reset mid-operation ----
    drive(1'b0, 1'b1, 64'h6000, 1'b0);
    drive(1'b0, 1'b1, 64'h6004, 1'b0);
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    chk("pre_arst_count", count, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_deq_valid", deq_valid, 0);
    chk("arst_deq_pc", deq_pc, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- randomized traffic against a reference queue ----
    mq.delete();
    for (int i = 0; i < 2000; i++) begin
      int   thr, sz;
      logic f, ev, dr, dv_e, deq_e, enq_e;
      ent_t hd;
      thr = (i / 250) % 4;
      f   = ($urandom_range(0, 24) == 0);
      ev  = ($urandom_range(0, 3) != 0);
      dr  = ($urandom_range(0, 3) < thr);
      drive(f, ev, {$urandom, $urandom} & ~64'h3, dr);

      sz   = mq.size();
      dv_e = !f && (sz > 0 || (BYP && ev));
      hd   = (sz > 0) ? mq[0] : ent_t'{pc: enq_pc, inst: enq_inst};
      chk("rnd_count", count, sz);
      chk("rnd_full", full, sz == D);
      chk("rnd_empty", empty, sz == 0);
      chk("rnd_enq_ready", enq_ready, sz != D);
      chk("rnd_deq_valid", deq_valid, dv_e);
      chk("rnd_deq_pc", deq_pc, dv_e ? hd.pc : 64'h0);
      chk("rnd_deq_pc4", deq_pc4, dv_e ? hd.pc + 64'd4 : 64'h0);
      chk("rnd_deq_inst", deq_inst, dv_e ? hd.inst : 32'h0);

      if (f) begin
        mq.delete();
      end else begin
        deq_e = dv_e && dr;
        enq_e = ev && (sz != D);
        if (BYP && sz == 0 && deq_e) begin
          // consumed straight from the input, never stored
        end else begin
          if (deq_e) void'(mq.pop_front());
          if (enq_e) mq.push_back(ent_t'{pc: enq_pc, inst: enq_inst});
        end
      end
      if (fails > 50) break;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. Captures fetched `{pc, inst}` pairs into a small circular FIFO and presents them to decode through a valid/ready handshake. Absorbs decode stalls without back-pressuring fetch until full. Redirects (branch, jump, JALR) discard all queued wrong-path instructions via `flush`.

## Interface
- `ADDR_WIDTH`, 64: PC width.
- `INST_WIDTH`, 32: instruction word width.
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `flush`  in  1: discard all entries and any same-cycle enqueue.
- `enq_valid`  in  1: fetch presents an instruction.
- `enq_pc`  in  ADDR_WIDTH: PC of the presented instruction.
- `enq_inst`  in  INST_WIDTH: presented instruction word.
- `enq_ready`  out  1: queue accepts this cycle; `= !full`.
- `deq_valid`  out  1: head entry valid to decode.
- `deq_ready`  in  1: decode consumes the head this cycle.
- `deq_pc`  out  ADDR_WIDTH: head PC.
- `deq_pc4`  out  ADDR_WIDTH: `deq_pc + 4`, modulo 2^ADDR_WIDTH.
- `deq_inst`  out  INST_WIDTH: head instruction.
- `empty`  out  1: count == 0.
- `full`  out  1: count == DEPTH.
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: DEPTH entries; read and write pointers are $clog2(DEPTH)+1 bits wide, with an extra wrap bit. `full` when the index bits are equal and the wrap bits differ. `empty` when the pointers are equal.
- Enqueue fires on `enq_valid && enq_ready && !flush`: write the entry at `wptr`, then increment `wptr`.
- Dequeue fires on `deq_valid && deq_ready`: increment `rptr`.
- Simultaneous enqueue and dequeue: both fire and `count` is unchanged. This is legal at every occupancy except full; no enqueue occurs when full, even if a dequeue fires in the same cycle.
- Flush has the highest priority. Next edge: `rptr = wptr = 0`, `count = 0`. Any enqueue or dequeue in the flush cycle is dropped. During the flush cycle `deq_valid` is forced to 0.
- `deq_valid = !empty && !flush`.
- When `deq_valid` is 0, `deq_pc`, `deq_pc4` and `deq_inst` are driven to 0. This keeps idle outputs deterministic for the bench.
- Pointers wrap naturally at 2·DEPTH. There is no special case at the wrap.
- There is no state machine beyond the pointers. `count = wptr − rptr`, computed modulo the pointer width.

## Timing
- Reset (asynchronous assert, synchronous-safe release): pointers 0, `count` 0, `empty` 1, `full` 0, `enq_ready` 1, `deq_valid` 0, all `deq_*` data 0. Entry storage is not reset.
- Reset mid-operation clears all contents immediately, with no edge required.
- Enqueue-to-dequeue latency is 1 cycle: an entry written at edge N is visible with `deq_valid` in cycle N+1.
- `enq_ready`, `full`, `empty` and `count` are register-derived only. They have no combinational path from `enq_valid` or `deq_ready`.
- `deq_valid` has a combinational path from `flush` only.
- After a flush at edge N, the first new enqueue is accepted in cycle N+1 and dequeued no earlier than N+2.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When the queue is empty, `enq_valid` is 1 and `flush` is 0, the queue drives `deq_valid = 1` with the enq data in the same cycle.
  - If `deq_ready` is also 1, the entry is consumed and is not written; the pointers are unchanged.
  - If `deq_ready` is 0, the entry is enqueued normally.
  - Latency becomes 0 cycles on the empty path.
  - This adds a combinational path from `enq_*` to `deq_*`.
- Undefined: no bypass; minimum latency is 1 cycle as specified above.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_entry_t` packed struct `{pc, inst}` parameterised by the widths.
  - `PC_INC = 4` constant, also used by the fetch stage for the +4 increment.
- One sub-module, `fetch_queue_ram`:
  - DEPTH × entry register array.
  - One write port, one asynchronous read port.
  - No reset.
- Pointer, flag and bypass logic live in `fetch_queue`.

## Test plan
- Reset → `empty=1`, `enq_ready=1`, `deq_valid=0`, `count=0`, `deq_pc=0`.
- Fill: enqueue PCs 0x1000, 0x1004, 0x1008, 0x100C (`deq_ready=0`) → `full=1`, `count=4`, `enq_ready=0`; a fifth `enq_valid` at PC 0x1010 is not stored.
- Drain with `deq_ready=1` → outputs appear in order 0x1000…0x100C, with `deq_pc4` values 0x1004…0x1010; then `empty=1`.
- Steady stream: enqueue and dequeue every cycle for 20 cycles across a pointer wrap → `count` constant at 1, no loss or duplication.
- Wrap edge: `enq_pc = 0xFFFF_FFFF_FFFF_FFFC` → `deq_pc4 = 0`.
- Flush with 3 entries plus a same-cycle `enq_valid` (PC 0x2000) → `deq_valid=0` in that cycle; next cycle `count=0`; enqueue PC 0x3000 → 0x3000 is the next dequeued entry.
- Bypass (macro defined): empty, `enq_valid=1` with PC 0x4000, `deq_ready=1` → `deq_valid=1` and `deq_pc=0x4000` in the same cycle; `count` stays 0.
